// File: rtl/control_turnos_pkg.sv
// Shared types and constants for the two-player turn sequencer.
package control_turnos_pkg;

    typedef enum logic [2:0] {
        INICIO = 3'd0,
        CARGA  = 3'd1,
        TURNO  = 3'd2,
        AUTO   = 3'd3,
        CAMBIO = 3'd4,
        FIN    = 3'd5
    } estado_t;

    localparam logic JUGADOR_1 = 1'b0;
    localparam logic JUGADOR_2 = 1'b1;

    localparam logic [1:0] GANADOR_NINGUNO = 2'b00;
    localparam logic [1:0] GANADOR_J1      = 2'b01;
    localparam logic [1:0] GANADOR_J2      = 2'b10;

endpackage

// File: rtl/contador_faltas.sv
// Per-player saturating count of consecutive timeouts.
module contador_faltas #(
    parameter int unsigned MAX_FALTAS = 3,
    parameter int unsigned ANCHO      = $clog2(MAX_FALTAS + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic limpiar,
    input  logic incrementar,
    output logic alcanzado
);
    localparam logic [ANCHO-1:0] MAXIMO = ANCHO'(MAX_FALTAS);

    logic [ANCHO-1:0] cuenta_d, cuenta_q;

    always_comb begin
        cuenta_d = cuenta_q;
        if (limpiar) begin
            cuenta_d = '0;
        end else if (incrementar && (cuenta_q != MAXIMO)) begin
            cuenta_d = cuenta_q + ANCHO'(1);
        end
    end

    // Looks at the next value so the FSM can act on the increment that reaches the limit.
    assign alcanzado = (cuenta_d == MAXIMO);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cuenta_q <= '0;
        end else begin
            cuenta_q <= cuenta_d;
        end
    end

endmodule

// File: rtl/control_turnos.sv
// Two-player turn sequencer: restarts the move timer each turn, handles timeouts,
// automatic moves and loss by abandonment. All outputs are registered.
module control_turnos
    import control_turnos_pkg::*;
#(
    parameter int unsigned MAX_FALTAS      = 3,
    parameter int unsigned ESPERA_AUTO_MAX = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jugada_valida,
    input  logic       fin_partida,
    input  logic       tiempo_agotado,
    input  logic       auto_hecha,
    output logic       reset_temporizador,
    output logic       enable_temporizador,
    output logic       jugador_actual,
    output logic       solicitar_auto,
    output logic       turno_activo,
    output logic       juego_terminado,
    output logic [1:0] ganador_tiempo,
    output logic [2:0] estado
);
    localparam int unsigned ANCHO_WD = $clog2(ESPERA_AUTO_MAX + 1);
    localparam logic [ANCHO_WD-1:0] WD_ULTIMO = ANCHO_WD'(ESPERA_AUTO_MAX - 1);

    estado_t               estado_d, estado_q;
    logic                  jugador_d, jugador_q;
    logic [1:0]            ganador_d, ganador_q;
    logic [ANCHO_WD-1:0]   wd_d, wd_q;
    logic [1:0]            limpiar, incrementar, alcanzado;
    logic                  reset_temp_q, enable_temp_q, solicitar_q, turno_q, terminado_q;

    contador_faltas #(.MAX_FALTAS(MAX_FALTAS)) u_faltas_j1 (
        .clk         (clk),
        .reset       (reset),
        .limpiar     (limpiar[0]),
        .incrementar (incrementar[0]),
        .alcanzado   (alcanzado[0])
    );

    contador_faltas #(.MAX_FALTAS(MAX_FALTAS)) u_faltas_j2 (
        .clk         (clk),
        .reset       (reset),
        .limpiar     (limpiar[1]),
        .incrementar (incrementar[1]),
        .alcanzado   (alcanzado[1])
    );

    always_comb begin
        estado_d    = estado_q;
        jugador_d   = jugador_q;
        ganador_d   = ganador_q;
        wd_d        = wd_q;
        limpiar     = 2'b00;
        incrementar = 2'b00;
        case (estado_q)
            INICIO: begin
                jugador_d = JUGADOR_1;
                ganador_d = GANADOR_NINGUNO;
                limpiar   = 2'b11;
                if (iniciar) estado_d = CARGA;
            end
            CARGA: estado_d = TURNO;
            TURNO: begin
                if (fin_partida) begin
                    estado_d  = FIN;
                    ganador_d = GANADOR_NINGUNO;
                end else if (jugada_valida) begin
                    limpiar[jugador_q] = 1'b1;
                    estado_d           = CAMBIO;
                end else if (tiempo_agotado) begin
                    incrementar[jugador_q] = 1'b1;
                    if (alcanzado[jugador_q]) begin
                        estado_d  = FIN;
                        ganador_d = (jugador_q == JUGADOR_1) ? GANADOR_J2 : GANADOR_J1;
                    end else begin
                        estado_d = AUTO;
                        wd_d     = '0;
                    end
                end
            end
            AUTO: begin
                if (fin_partida) begin
                    estado_d  = FIN;
                    ganador_d = GANADOR_NINGUNO;
                end else if (auto_hecha || (wd_q == WD_ULTIMO)) begin
                    estado_d = CAMBIO;
                end else begin
                    wd_d = wd_q + ANCHO_WD'(1);
                end
            end
            CAMBIO: begin
                jugador_d = ~jugador_q;
                estado_d  = CARGA;
            end
            FIN: begin
                if (iniciar) begin
                    estado_d  = CARGA;
                    jugador_d = JUGADOR_1;
                    ganador_d = GANADOR_NINGUNO;
                    limpiar   = 2'b11;
                end
            end
            default: begin
                estado_d  = INICIO;
                jugador_d = JUGADOR_1;
                ganador_d = GANADOR_NINGUNO;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q      <= INICIO;
            jugador_q     <= JUGADOR_1;
            ganador_q     <= GANADOR_NINGUNO;
            wd_q          <= '0;
            reset_temp_q  <= 1'b0;
            enable_temp_q <= 1'b0;
            solicitar_q   <= 1'b0;
            turno_q       <= 1'b0;
            terminado_q   <= 1'b0;
        end else begin
            estado_q      <= estado_d;
            jugador_q     <= jugador_d;
            ganador_q     <= ganador_d;
            wd_q          <= wd_d;
            reset_temp_q  <= (estado_d == CARGA);
            enable_temp_q <= (estado_d == TURNO);
            solicitar_q   <= (estado_d == AUTO);
            turno_q       <= (estado_d == TURNO);
            terminado_q   <= (estado_d == FIN);
        end
    end

    assign reset_temporizador  = reset_temp_q;
    assign enable_temporizador = enable_temp_q;
    assign jugador_actual      = jugador_q;
    assign solicitar_auto      = solicitar_q;
    assign turno_activo        = turno_q;
    assign juego_terminado     = terminado_q;
    assign ganador_tiempo      = ganador_q;
    assign estado              = estado_q;

endmodule

// File: doc/control_turnos.md
# control_turnos

Two-player turn sequencer for the Lab3 game: sits directly upstream of `temporizador_10s` and consumes its `tiempo_agotado`. Each turn it restarts the 10 s timer, waits for the current player's move or a timeout, and hands the turn over. On timeout it requests an automatic move and counts consecutive timeouts per player. It declares loss by abandonment after `MAX_FALTAS` consecutive timeouts.

## Interface
- `MAX_FALTAS`, 3: consecutive timeouts that end the game; legal range 1..7.
- `ESPERA_AUTO_MAX`, 1024: watchdog limit on `auto_hecha`, in cycles; minimum 2.
- `clk` in 1: 25 MHz system clock, the only clock.
- `reset` in 1: asynchronous, active-high; forces state `INICIO` and every output to 0.
- `iniciar` in 1: start/restart pulse, 1 cycle, synchronous to `clk`.
- `jugada_valida` in 1: current player committed a legal move, 1-cycle pulse.
- `fin_partida` in 1: level from board logic; win or draw detected.
- `tiempo_agotado` in 1: from the timer.
- `auto_hecha` in 1: 1-cycle ack from the automatic-move generator.
- `reset_temporizador` out 1: timer restart. Top level ORs it with `reset`.
- `enable_temporizador` out 1: timer count enable.
- `jugador_actual` out 1: 0 = J1, 1 = J2.
- `solicitar_auto` out 1: level; automatic move requested for `jugador_actual`.
- `turno_activo` out 1: high in `TURNO`.
- `juego_terminado` out 1: high in `FIN`.
- `ganador_tiempo` out 2: 00 none, 01 J1 wins, 10 J2 wins (opponent abandoned); 11 unused.
- `estado` out 3: current state code, for debug LEDs.

## Operation
- States: `INICIO`=0, `CARGA`=1, `TURNO`=2, `AUTO`=3, `CAMBIO`=4, `FIN`=5. Codes 6 and 7 return to `INICIO`.
- `INICIO`: all outputs 0, fault counters cleared, `jugador_actual`=0. `iniciar` → `CARGA`.
- `CARGA`: `reset_temporizador`=1 for exactly 1 cycle, then → `TURNO`.
- `TURNO`: `enable_temporizador`=1 and `turno_activo`=1. Events are evaluated in priority order; only one fires per cycle:
  - `fin_partida` → `FIN`, `ganador_tiempo`=00.
  - `jugada_valida` → clear current player's fault counter, then → `CAMBIO`.
  - `tiempo_agotado` → increment current player's fault counter. If the new value equals `MAX_FALTAS` → `FIN`, with `ganador_tiempo` set to the opponent. Otherwise → `AUTO`.
- `AUTO`: `solicitar_auto`=1, timer disabled, `jugada_valida` ignored.
  - `fin_partida` → `FIN`.
  - `auto_hecha` → `CAMBIO`.
  - Watchdog: after `ESPERA_AUTO_MAX` cycles without ack → `CAMBIO`. The fault counter is not incremented again.
- `CAMBIO`: 1 cycle; toggles `jugador_actual` on exit, then → `CARGA`.
- `FIN`: `juego_terminado`=1; `ganador_tiempo` and `jugador_actual` are held. `iniciar` → `CARGA` with counters cleared, `jugador_actual`=0, `ganador_tiempo`=00.
- `iniciar` is ignored in every state except `INICIO` and `FIN`.
- Fault counters: one per player, width $clog2(MAX_FALTAS+1), saturating. The counter of the player not on turn is never modified.
- Watchdog counter: cleared on `AUTO` entry, width $clog2(ESPERA_AUTO_MAX+1).

## Timing
- All outputs are registered, computed from next-state, so they change only on the edge that enters a state. There are no combinational paths from input to output. `reset_temporizador` is glitch-free.
- Move taken at edge k (in `TURNO`):
  - `enable_temporizador` falls after k.
  - State is `CAMBIO` after k.
  - `CARGA` after k+1, with `jugador_actual` toggled and `reset_temporizador` high.
  - `TURNO` after k+2, timer reloaded to 10.
- Timeout at edge k → `solicitar_auto` high after k. `auto_hecha` at edge m → `solicitar_auto` low after m, `CAMBIO` after m.
- The timer is frozen throughout `AUTO`, `CAMBIO` and `FIN`, and in `CARGA` except for its reload.
- Board logic sees at least 2 cycles (`CAMBIO`, `CARGA`) after a move before `TURNO` samples `fin_partida`. It must deassert `fin_partida` within 1 cycle of `iniciar`.
- Async `reset` mid-turn: outputs go to 0 immediately, without waiting for a clock edge. The first post-reset edge leaves the block in `INICIO`.

## Structure
- `control_turnos_pkg`:
  - `estado_t` enum with the codes above.
  - `JUGADOR_1`=0 and `JUGADOR_2`=1.
  - `GANADOR_NINGUNO`/`GANADOR_J1`/`GANADOR_J2` constants.
- Sub-module `contador_faltas`: saturating counter with synchronous clear and increment, plus an `alcanzado` flag comparing against `MAX_FALTAS`. Instantiated twice, once per player.
- The watchdog counter stays inline.

## Test plan
- `iniciar` → after 1 cycle `reset_temporizador`=1 for one cycle, `jugador_actual`=0. `jugada_valida` at edge k → `TURNO` with `jugador_actual`=1 after k+2.
- Timeout for J1 with `auto_hecha` 5 cycles later → `solicitar_auto` high for exactly 5 cycles, then turn passes to J2 and J1's fault count is 1.
- J1 times out 3 times (`MAX_FALTAS`=3) with J2 moving in between → `FIN`, `ganador_tiempo`=10, `juego_terminado`=1.
- Timeout, J1 moves, then timeout again → J1's counter is cleared by the move, so no `FIN` after 3 total non-consecutive timeouts.
- `auto_hecha` never arrives → `CAMBIO` exactly `ESPERA_AUTO_MAX` cycles after `AUTO` entry.
- `fin_partida`, `jugada_valida` and `tiempo_agotado` in the same cycle → `FIN` with `ganador_tiempo`=00. Async `reset` mid-`AUTO` → all outputs 0 immediately, state `INICIO`.
